nvme_host_init_seq: RTL and testbench

//  Host-side initiator that brings an NVMe controller register block from reset to enabled.

---
 rtl/nvme_pkg.sv | 56 +++++
 rtl/nvme_reg_txn.sv | 65 ++++++
 rtl/nvme_host_init_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_nvme_host_init_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_pkg.sv
// Shared NVMe register map, CC/CSTS bit positions, error codes and FSM state encodings
// used by the host bring-up sequencer and its register transaction engine.
package nvme_pkg;

  localparam logic [15:0] REG_CAPL = 16'h0000;
  localparam logic [15:0] REG_CAPH = 16'h0004;
  localparam logic [15:0] REG_CC   = 16'h0014;
  localparam logic [15:0] REG_CSTS = 16'h001C;
  localparam logic [15:0] REG_AQA  = 16'h0024;
  localparam logic [15:0] REG_ASQL = 16'h0028;
  localparam logic [15:0] REG_ASQH = 16'h002C;
  localparam logic [15:0] REG_ACQL = 16'h0030;
  localparam logic [15:0] REG_ACQH = 16'h0034;

  localparam int CC_EN_BIT     = 0;
  localparam int CC_MPS_LSB    = 7;
  localparam int CC_IOSQES_LSB = 16;
  localparam int CC_IOCQES_LSB = 20;
  localparam int CSTS_RDY_BIT  = 0;
  localparam int CSTS_CFS_BIT  = 1;

  localparam logic [3:0] CC_IOSQES = 4'd6;
  localparam logic [3:0] CC_IOCQES = 4'd4;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_DIS_TO = 3'd1,
    ERR_EN_TO  = 3'd2,
    ERR_CFS    = 3'd3,
    ERR_AQA    = 3'd4,
    ERR_ALIGN  = 3'd5
  } err_code_e;

  typedef enum logic [4:0] {
    S_IDLE, S_RD_CAPL, S_RD_CAPH, S_WR_CC_DIS, S_POLL_DIS, S_GAP_DIS,
    S_WR_AQA, S_WR_ASQL, S_WR_ASQH, S_WR_ACQL, S_WR_ACQH, S_CHK_AQA,
    S_WR_CC_EN, S_POLL_RDY, S_GAP_RDY, S_DONE, S_ERR
  } seq_state_e;

  typedef enum logic {
    TXN_IDLE,
    TXN_RD2
  } txn_state_e;

  // SHN, AMS and CSS stay zero; only queue entry sizes, MPS and EN are set.
  function automatic logic [31:0] cc_enable(input logic [3:0] mps);
    logic [31:0] v;
    v = '0;
    v[CC_IOCQES_LSB +: 4] = CC_IOCQES;
    v[CC_IOSQES_LSB +: 4] = CC_IOSQES;
    v[CC_MPS_LSB +: 4]    = mps;
    v[CC_EN_BIT]          = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/nvme_reg_txn.sv
// Register-port transaction engine: writes complete in 1 cycle, reads hold the address
// for 2 cycles and ack in the 2nd, when the target's registered read data is valid.
module nvme_reg_txn
  import nvme_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data
);

  txn_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TXN_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ack         = 1'b0;
    reg_addr    = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    case (state_q)
      TXN_IDLE: begin
        if (req) begin
          reg_addr = req_addr;
          if (req_wr) begin
            reg_wr_en   = 1'b1;
            reg_wr_data = req_wdata;
            ack         = 1'b1;
          end else begin
            addr_d  = req_addr;
            state_d = TXN_RD2;
          end
        end
      end
      TXN_RD2: begin
        reg_addr = addr_q;
        ack      = 1'b1;
        state_d  = TXN_IDLE;
      end
      default: state_d = TXN_IDLE;
    endcase
  end

  assign rdata = reg_rd_data;

endmodule

// File: rtl/nvme_host_init_seq.sv
// Host-side NVMe bring-up sequencer: reads CAP, disables, waits !RDY, programs the admin
// queues, verifies AQA, enables and waits RDY, with CAP.TO-scaled poll timeouts.
module nvme_host_init_seq
  import nvme_pkg::*;
#(
  parameter int TIMEOUT_UNIT_CYC = 1000,
  parameter int POLL_GAP         = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] asq_base,
  input  logic [63:0] acq_base,
  input  logic [11:0] asqs,
  input  logic [11:0] acqs,
  input  logic [3:0]  cfg_mps,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] cap_mqes,
  output logic [7:0]  cap_to,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  seq_state_e  state_q, state_d;
  err_code_e   err_q, err_d;
  logic [63:0] asq_q, asq_d, acq_q, acq_d;
  logic [11:0] asqs_q, asqs_d, acqs_q, acqs_d;
  logic [3:0]  mps_q, mps_d;
  logic [15:0] mqes_q, mqes_d;
  logic [7:0]  to_q, to_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;

  logic        txn_req, txn_wr, txn_ack;
  logic [15:0] txn_addr;
  logic [31:0] txn_wdata, txn_rdata;
  logic [31:0] aqa_val, tmo_limit;
  logic        poll_want_rdy, poll_match, poll_expired;

  assign aqa_val       = {4'b0, acqs_q, 4'b0, asqs_q};
  assign tmo_limit     = (to_q == 8'd0 ? 32'd1 : {24'd0, to_q}) * 32'(TIMEOUT_UNIT_CYC);
  assign poll_want_rdy = (state_q == S_POLL_RDY);
  assign poll_match    = (txn_rdata[CSTS_RDY_BIT] == poll_want_rdy);
  assign poll_expired  = (tmo_q >= tmo_limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      asq_q   <= '0;
      acq_q   <= '0;
      asqs_q  <= '0;
      acqs_q  <= '0;
      mps_q   <= '0;
      mqes_q  <= '0;
      to_q    <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      asq_q   <= asq_d;
      acq_q   <= acq_d;
      asqs_q  <= asqs_d;
      acqs_q  <= acqs_d;
      mps_q   <= mps_d;
      mqes_q  <= mqes_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    asq_d     = asq_q;
    acq_d     = acq_q;
    asqs_d    = asqs_q;
    acqs_d    = acqs_q;
    mps_d     = mps_q;
    mqes_d    = mqes_q;
    to_d      = to_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    txn_req   = 1'b0;
    txn_wr    = 1'b0;
    txn_addr  = '0;
    txn_wdata = '0;
    // Timeout runs across poll reads and the idle gaps between them.
    if (state_q inside {S_POLL_DIS, S_GAP_DIS, S_POLL_RDY, S_GAP_RDY}) tmo_d = tmo_q + 32'd1;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          asq_d  = asq_base;
          acq_d  = acq_base;
          asqs_d = asqs;
          acqs_d = acqs;
          mps_d  = cfg_mps;
          err_d  = ERR_NONE;
          if (asq_base[11:0] != 12'd0 || acq_base[11:0] != 12'd0) begin
            state_d = S_ERR;
            err_d   = ERR_ALIGN;
          end else begin
            state_d = S_RD_CAPL;
          end
        end
      end
      S_RD_CAPL: begin
        txn_req  = 1'b1;
        txn_addr = REG_CAPL;
        if (txn_ack) begin
          mqes_d  = txn_rdata[15:0];
          to_d    = txn_rdata[31:24];
          state_d = S_RD_CAPH;
        end
      end
      S_RD_CAPH: begin
        txn_req  = 1'b1;
        txn_addr = REG_CAPH;
        if (txn_ack) state_d = S_WR_CC_DIS;
      end
      S_WR_CC_DIS: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_CC;
        if (txn_ack) begin
          tmo_d   = '0;
          state_d = S_POLL_DIS;
        end
      end
      S_POLL_DIS, S_POLL_RDY: begin
        txn_req  = 1'b1;
        txn_addr = REG_CSTS;
        if (txn_ack) begin
          // CFS outranks a RDY match, which in turn outranks an expired timeout.
          if (txn_rdata[CSTS_CFS_BIT]) begin
            state_d = S_ERR;
            err_d   = ERR_CFS;
          end else if (poll_match) begin
            state_d = poll_want_rdy ? S_DONE : S_WR_AQA;
          end else if (poll_expired) begin
            state_d = S_ERR;
            err_d   = poll_want_rdy ? ERR_EN_TO : ERR_DIS_TO;
          end else begin
            state_d = poll_want_rdy ? S_GAP_RDY : S_GAP_DIS;
            gap_d   = '0;
          end
        end
      end
      S_GAP_DIS, S_GAP_RDY: begin
        if (gap_q == GAP_LAST) state_d = (state_q == S_GAP_RDY) ? S_POLL_RDY : S_POLL_DIS;
        else gap_d = gap_q + 8'd1;
      end
      S_WR_AQA: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_AQA; txn_wdata = aqa_val;
        if (txn_ack) state_d = S_WR_ASQL;
      end
      S_WR_ASQL: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_ASQL; txn_wdata = asq_q[31:0];
        if (txn_ack) state_d = S_WR_ASQH;
      end
      S_WR_ASQH: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_ASQH; txn_wdata = asq_q[63:32];
        if (txn_ack) state_d = S_WR_ACQL;
      end
      S_WR_ACQL: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_ACQL; txn_wdata = acq_q[31:0];
        if (txn_ack) state_d = S_WR_ACQH;
      end
      S_WR_ACQH: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_ACQH; txn_wdata = acq_q[63:32];
        if (txn_ack) state_d = S_CHK_AQA;
      end
      S_CHK_AQA: begin
        txn_req  = 1'b1;
        txn_addr = REG_AQA;
        if (txn_ack) begin
          if (txn_rdata != aqa_val) begin
            state_d = S_ERR;
            err_d   = ERR_AQA;
          end else begin
            state_d = S_WR_CC_EN;
          end
        end
      end
      S_WR_CC_EN: begin
        txn_req = 1'b1; txn_wr = 1'b1; txn_addr = REG_CC; txn_wdata = cc_enable(mps_q);
        if (txn_ack) begin
          tmo_d   = '0;
          state_d = S_POLL_RDY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  nvme_reg_txn u_txn (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (txn_req),
    .req_wr      (txn_wr),
    .req_addr    (txn_addr),
    .req_wdata   (txn_wdata),
    .ack         (txn_ack),
    .rdata       (txn_rdata),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_data (reg_rd_data)
  );

  assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign err_code = err_q;
  assign cap_mqes = mqes_q;
  assign cap_to   = to_q;

endmodule

// File: tb/tb_nvme_host_init_seq.sv
// Bench for nvme_host_init_seq: behavioural register target plus an expected-transaction
// model derived from the bring-up order, covering success, each error code and mid-run reset.
module tb_nvme_host_init_seq;

  localparam int TUC = 50;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [63:0] asq_base, acq_base;
  logic [11:0] asqs, acqs;
  logic [3:0]  cfg_mps;
  logic        busy, done, error, reg_wr_en;
  logic [2:0]  err_code;
  logic [15:0] cap_mqes, reg_addr;
  logic [7:0]  cap_to;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data = '0;

  always #5 clk = ~clk;

  nvme_host_init_seq #(.TIMEOUT_UNIT_CYC(TUC), .POLL_GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .asq_base(asq_base), .acq_base(acq_base),
    .asqs(asqs), .acqs(acqs), .cfg_mps(cfg_mps), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .cap_mqes(cap_mqes), .cap_to(cap_to), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en), .reg_rd_data(reg_rd_data)
  );

  // Target: CSTS.RDY follows CC.EN ten cycles later; modes force stuck/faulty status.
  logic [31:0] cap_lo = '0, cap_hi = '0, cc_r = '0, aqa_r = '0;
  logic        rdy_q = 1'b0;
  int          rdy_cnt = 0;
  int          csts_mode = 0;
  bit          aqa_zero = 1'b0;

  function automatic logic [31:0] tgt_read(input logic [15:0] a);
    case (a)
      16'h0000: return cap_lo;
      16'h0004: return cap_hi;
      16'h0014: return cc_r;
      16'h001C: case (csts_mode)
                  1: return 32'h0;
                  2: return 32'h1;
                  3: return cc_r[0] ? 32'h2 : 32'h0;
                  default: return {31'd0, rdy_q};
                endcase
      16'h0024: return aqa_zero ? 32'h0 : aqa_r;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reg_wr_en && reg_addr == 16'h0014) cc_r <= reg_wr_data;
    if (reg_wr_en && reg_addr == 16'h0024) aqa_r <= reg_wr_data;
    if (cc_r[0] != rdy_q) begin
      if (rdy_cnt == 9) begin
        rdy_q   <= cc_r[0];
        rdy_cnt <= 0;
      end else rdy_cnt <= rdy_cnt + 1;
    end else rdy_cnt <= 0;
    reg_rd_data <= tgt_read(reg_addr);
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          len;
  } ev_t;

  ev_t log_q[$];
  ev_t exp_q[$];
  int  n_chk = 0, n_pass = 0;
  int  r_ndone, r_wr, r_en_cyc, r_end_cyc;
  bit  r_fin, r_first_busy, r_first_err, r_busy_end, r_busy_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void add_exp(input bit wr, input logic [15:0] a, input logic [31:0] d);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d; e.len = 1;
    exp_q.push_back(e);
  endfunction

  // CAP low sits at address 0 and is indistinguishable from an idle bus, so it is checked via cap_*.
  function automatic void build_exp(input logic [63:0] sq, input logic [63:0] cq,
                                    input logic [11:0] s, input logic [11:0] c, input logic [3:0] m);
    exp_q.delete();
    add_exp(0, 16'h04, 0);
    add_exp(1, 16'h14, 0);
    add_exp(0, 16'h1C, 0);
    add_exp(1, 16'h24, {4'h0, c, 4'h0, s});
    add_exp(1, 16'h28, sq[31:0]);
    add_exp(1, 16'h2C, sq[63:32]);
    add_exp(1, 16'h30, cq[31:0]);
    add_exp(1, 16'h34, cq[63:32]);
    add_exp(0, 16'h24, 0);
    add_exp(1, 16'h14, 32'h0046_0001 | (32'(m) << 7));
    add_exp(0, 16'h1C, 0);
  endfunction

  task automatic run_seq(input logic [63:0] sq, input logic [63:0] cq, input logic [11:0] s,
                         input logic [11:0] c, input logic [3:0] m, input bit poke);
    int  cyc;
    int  k;
    ev_t e;
    log_q.delete();
    r_ndone = 0; r_wr = 0; r_en_cyc = -1; r_end_cyc = -1; r_fin = 0; r_busy_at_done = 0;
    @(negedge clk);
    asq_base = sq; acq_base = cq; asqs = s; acqs = c; cfg_mps = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    asq_base = {$urandom, $urandom}; acq_base = {$urandom, $urandom};
    asqs = 12'($urandom); acqs = 12'($urandom); cfg_mps = 4'($urandom);
    r_first_busy = busy; r_first_err = error;
    cyc = 0;
    while (!r_fin && cyc < 3000) begin
      cyc++;
      start = (poke && cyc == 20);
      if (reg_wr_en) begin
        r_wr++;
        e.wr = 1; e.addr = reg_addr; e.data = reg_wr_data; e.len = 1;
        log_q.push_back(e);
        if (reg_addr == 16'h14 && reg_wr_data[0]) r_en_cyc = cyc;
      end else if (reg_addr != 16'h0) begin
        k = log_q.size() - 1;
        if (k >= 0 && !log_q[k].wr && log_q[k].addr == reg_addr) log_q[k].len = log_q[k].len + 1;
        else begin
          e.wr = 0; e.addr = reg_addr; e.data = 0; e.len = 1;
          log_q.push_back(e);
        end
      end
      if (done) begin
        r_ndone++;
        r_busy_at_done = busy;
      end
      if (error || (r_ndone > 0 && !done)) begin
        r_fin = 1;
        r_end_cyc = cyc;
        r_busy_end = busy;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("run_finished", 64'(r_fin), 1);
  endtask

  task automatic compare_log();
    int n;
    check("txn_count", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("txn%0d", i), {log_q[i].wr, log_q[i].addr, log_q[i].data},
            {exp_q[i].wr, exp_q[i].addr, exp_q[i].data});
      if (!log_q[i].wr) check($sformatf("txn%0d_rd_len_even", i), 64'(log_q[i].len % 2), 0);
    end
  endtask

  task automatic normal_run(input bit poke, input logic [7:0] to);
    logic [63:0] sq, cq;
    logic [11:0] s, c;
    logic [3:0]  m;
    csts_mode = 0; aqa_zero = 0;
    cap_lo = {to, 8'($urandom), 16'($urandom)}; cap_hi = $urandom;
    sq = {$urandom, 20'($urandom), 12'h0}; cq = {$urandom, 20'($urandom), 12'h0};
    s = 12'($urandom); c = 12'($urandom); m = 4'($urandom);
    build_exp(sq, cq, s, c, m);
    run_seq(sq, cq, s, c, m, poke);
    check("ok_first_busy", 64'(r_first_busy), 1);
    check("ok_first_error", 64'(r_first_err), 0);
    check("ok_done_pulses", r_ndone, 1);
    check("ok_busy_at_done", 64'(r_busy_at_done), 0);
    check("ok_busy_end", 64'(r_busy_end), 0);
    check("ok_err_code", 64'(err_code), 0);
    check("ok_error", 64'(error), 0);
    check("ok_cap_mqes", cap_mqes, cap_lo[15:0]);
    check("ok_cap_to", cap_to, cap_lo[31:24]);
    compare_log();
  endtask

  task automatic err_run(input int mode, input bit aqaz, input logic [2:0] code, input string tag);
    logic [63:0] sq, cq;
    csts_mode = mode; aqa_zero = aqaz;
    cap_lo = {8'd0, 8'($urandom), 16'($urandom)};
    sq = {$urandom, 20'($urandom), 12'h0}; cq = {$urandom, 20'($urandom), 12'h0};
    run_seq(sq, cq, 12'($urandom), 12'($urandom), 4'($urandom), 1'b0);
    check({tag, "_first_err_cleared"}, 64'(r_first_err), 0);
    check({tag, "_err_code"}, 64'(err_code), 64'(code));
    check({tag, "_error"}, 64'(error), 1);
    check({tag, "_busy"}, 64'(r_busy_end), 0);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, error, err_code, reg_wr_en, reg_addr, cap_to}, 0);
    check({tag, "_dat"}, {reg_wr_data, cap_mqes}, 0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset_n = 1'b0; start = 1'b0; asq_base = '0; acq_base = '0; asqs = '0; acqs = '0; cfg_mps = '0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    normal_run(1'b0, 8'd2);
    for (int r = 1; r < 4; r++) normal_run(r[0], 8'($urandom));

    csts_mode = 0;
    run_seq(64'h1000_0800, 64'h2000_0000, 12'd7, 12'd7, 4'd0, 1'b0);
    check("align_error_next_cycle", 64'(r_first_err), 1);
    check("align_busy", 64'(r_first_busy), 0);
    check("align_err_code", 64'(err_code), 5);
    check("align_no_writes", r_wr, 0);
    check("align_no_bus", log_q.size(), 0);

    err_run(1, 1'b0, 3'd2, "en_to");
    lat = r_end_cyc - r_en_cyc;
    check("en_to_not_early", 64'(lat >= TUC + 1), 1);
    check("en_to_not_late", 64'(lat <= TUC + GAP + 6), 1);
    err_run(2, 1'b0, 3'd1, "dis_to");
    check("dis_to_no_enable", 64'(r_en_cyc), 64'(-1));
    err_run(3, 1'b0, 3'd3, "cfs");
    err_run(0, 1'b1, 3'd4, "aqa");
    check("aqa_no_enable", 64'(r_en_cyc), 64'(-1));

    csts_mode = 2; aqa_zero = 0;
    @(negedge clk);
    asq_base = 64'h4000_0000; acq_base = 64'h5000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (reg_addr == 16'h1C) seen = 1;
      else @(negedge clk);
    end
    check("rst_saw_poll_dis", 64'(seen), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_outs_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_wr", 64'(reg_wr_en), 0);
    end
    reset_n = 1'b1;
    normal_run(1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
